// File: rtl/key_expansion_ctrl_pkg.sv
// Shared definitions for the key expansion controller.
// Holds the z0 round-constant sequence, the additive constant, the FSM state type
// and a 16-bit rotate helper used by the round function.
package key_expansion_ctrl_pkg;

  // z0 sequence, consumed LSB first: z0[i] = Z0[i]
  localparam logic [61:0] Z0 =
    62'b01100111000011010100100010111110110011100001101010010001011111;

  localparam logic [15:0] C_CONST = 16'hFFFC;

  // Physical store depth; ROUNDS entries are used, the rest read back as zero
  localparam int unsigned STORE_DEPTH = 32;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StExpand = 2'd1,
    StDone   = 2'd2
  } state_e;

  function automatic logic [15:0] ror16(input logic [15:0] x, input int unsigned n);
    return (x >> n) | (x << (16 - n));
  endfunction

endpackage

// File: rtl/key_expansion_ctrl_if.sv
// Handshake / key-store bus of the key expansion controller.
// Signals: key_valid, key_ready, master_key[63:0] (key handshake),
//          busy, keys_ready, rnd_idx[4:0] (status),
//          rd_addr[4:0], rd_key[15:0] (round-key read port),
//          zeroize (only when KEY_EXP_ZEROIZE_EN is defined).
// master: the cipher side driving keys and read addresses; slave: the controller.
interface key_expansion_ctrl_if;
  logic        key_valid;
  logic        key_ready;
  logic [63:0] master_key;
  logic        busy;
  logic        keys_ready;
  logic [4:0]  rd_addr;
  logic [15:0] rd_key;
  logic [4:0]  rnd_idx;
`ifdef KEY_EXP_ZEROIZE_EN
  logic        zeroize;
`endif

  modport master (
`ifdef KEY_EXP_ZEROIZE_EN
    output zeroize,
`endif
    output key_valid, master_key, rd_addr,
    input  key_ready, busy, keys_ready, rd_key, rnd_idx
  );

  modport slave (
`ifdef KEY_EXP_ZEROIZE_EN
    input  zeroize,
`endif
    input  key_valid, master_key, rd_addr,
    output key_ready, busy, keys_ready, rd_key, rnd_idx
  );
endinterface

// File: rtl/key_round_fn.sv
// Combinational key schedule step (four-word key):
//   o_key = C ^ z ^ k[i] ^ t ^ ror1(t), t = ror3(k[i+3]) ^ k[i+1]
// Ports: i_k0 = k[i], i_k1 = k[i+1], i_k3 = k[i+3], i_z = z0[i], o_key = k[i+4].
// k[i+2] does not enter the four-word schedule, so it is not a port.
module key_round_fn
  import key_expansion_ctrl_pkg::*;
(
  input  logic [15:0] i_k0,
  input  logic [15:0] i_k1,
  input  logic [15:0] i_k3,
  input  logic        i_z,
  output logic [15:0] o_key
);
  logic [15:0] w_t;

  assign w_t   = ror16(i_k3, 3) ^ i_k1;
  assign o_key = C_CONST ^ {15'd0, i_z} ^ i_k0 ^ w_t ^ ror16(w_t, 1);
endmodule

// File: rtl/key_expansion_ctrl.sv
// Key expansion controller: accepts a 64-bit master key over a valid/ready
// handshake, expands it into ROUNDS 16-bit round keys (one per cycle) and serves
// them through a combinational read port once all are valid.
// Ports: clk, rst_n (async active-low), bus (key_expansion_ctrl_if.slave).
// Parameter: ROUNDS (5..32) round keys generated.
// Optional: KEY_EXP_ZEROIZE_EN adds bus.zeroize, which clears store and FSM.
module key_expansion_ctrl
  import key_expansion_ctrl_pkg::*;
#(
  parameter int unsigned ROUNDS = 32
) (
  input logic                 clk,
  input logic                 rst_n,
  key_expansion_ctrl_if.slave bus
);
  localparam logic [4:0] LastIdx = 5'(ROUNDS - 5);
  localparam logic [5:0] RoundsW = 6'(ROUNDS);

  state_e      r_state, w_state_nxt;
  logic [4:0]  r_idx, w_idx_nxt;
  logic        r_keys_ready, w_keys_ready_nxt;
  logic [15:0] r_store [STORE_DEPTH];
  logic        w_key_ready, w_accept, w_expand;
  logic [15:0] w_next_key;

  assign w_key_ready = (r_state != StExpand);
  assign w_expand    = (r_state == StExpand);
  assign w_accept    = bus.key_valid && w_key_ready;

  key_round_fn u_round_fn (
    .i_k0  (r_store[r_idx]),
    .i_k1  (r_store[r_idx + 5'd1]),
    .i_k3  (r_store[r_idx + 5'd3]),
    .i_z   (Z0[{1'b0, r_idx}]),
    .o_key (w_next_key)
  );

  always_comb begin
    w_state_nxt      = r_state;
    w_idx_nxt        = r_idx;
    w_keys_ready_nxt = r_keys_ready;
    case (r_state)
      StIdle, StDone: begin
        if (bus.key_valid) begin
          w_state_nxt      = StExpand;
          w_idx_nxt        = '0;
          w_keys_ready_nxt = 1'b0;
        end
      end
      StExpand: begin
        // Counter ends at ROUNDS-4 and holds there in DONE
        w_idx_nxt = r_idx + 5'd1;
        if (r_idx == LastIdx) begin
          w_state_nxt      = StDone;
          w_keys_ready_nxt = 1'b1;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
`ifdef KEY_EXP_ZEROIZE_EN
    // Zeroize wins over a simultaneous key acceptance
    if (bus.zeroize) begin
      w_state_nxt      = StIdle;
      w_idx_nxt        = '0;
      w_keys_ready_nxt = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_idx        <= '0;
      r_keys_ready <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_idx        <= w_idx_nxt;
      r_keys_ready <= w_keys_ready_nxt;
    end
  end

  // Store is deliberately unreset; its contents are only visible via keys_ready
  always_ff @(posedge clk) begin
`ifdef KEY_EXP_ZEROIZE_EN
    if (bus.zeroize) begin
      for (int n = 0; n < STORE_DEPTH; n++) r_store[n] <= '0;
    end else
`endif
    if (w_accept) begin
      r_store[0] <= bus.master_key[15:0];
      r_store[1] <= bus.master_key[31:16];
      r_store[2] <= bus.master_key[47:32];
      r_store[3] <= bus.master_key[63:48];
    end else if (w_expand) begin
      r_store[r_idx + 5'd4] <= w_next_key;
    end
  end

  assign bus.key_ready  = w_key_ready;
  assign bus.busy       = w_expand;
  assign bus.keys_ready = r_keys_ready;
  assign bus.rnd_idx    = w_expand ? r_idx : 5'd0;
  assign bus.rd_key     = (r_keys_ready && ({1'b0, bus.rd_addr} < RoundsW)) ?
                          r_store[bus.rd_addr] : 16'h0000;
endmodule

// File: tb/tb_key_expansion_ctrl.sv
// Directed bench for key_expansion_ctrl: a ROUNDS=32 instance for the main
// sequence and a ROUNDS=8 instance for the short-schedule / out-of-range reads.
module tb_key_expansion_ctrl;
  localparam logic [63:0] KeyA = 64'h1918_1110_0908_0100;
  localparam logic [63:0] KeyB = 64'hA5A5_5A5A_F00F_0FF0;
  localparam logic [63:0] KeyC = 64'hDEAD_BEEF_0123_4567;
  localparam logic [61:0] Z0Ref =
    62'b01100111000011010100100010111110110011100001101010010001011111;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  key_expansion_ctrl_if bus ();
  key_expansion_ctrl_if bus8 ();

  key_expansion_ctrl #(.ROUNDS(32)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  key_expansion_ctrl #(.ROUNDS(8)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  int n_total = 0;
  int n_pass  = 0;
  logic [15:0] exp_k [32];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h, required %0h", tag, obs, exp);
  endtask

  function automatic logic [15:0] rr(input logic [15:0] x, input int n);
    logic [31:0] d;
    d = {x, x} >> n;
    return d[15:0];
  endfunction

  // Reference key schedule
  task automatic gen_model(input logic [63:0] key);
    logic [15:0] t;
    for (int j = 0; j < 4; j++) exp_k[j] = key[16*j +: 16];
    for (int i = 0; i < 28; i++) begin
      t = rr(exp_k[i+3], 3) ^ exp_k[i+1];
      exp_k[i+4] = 16'hFFFC ^ (Z0Ref[i] ? 16'h0001 : 16'h0000) ^ exp_k[i] ^ t ^ rr(t, 1);
    end
  endtask

  // Called #1 after an edge with the DUT in IDLE or DONE
  task automatic expand_and_check(input logic [63:0] key, input bit hold,
                                  input logic [63:0] other);
    bus.rd_addr    = 5'd0;
    bus.master_key = key;
    bus.key_valid  = 1'b1;
    check("key_ready_pre", 64'(bus.key_ready), 64'd1);
    @(posedge clk); #1;
    if (hold) bus.master_key = other;
    else bus.key_valid = 1'b0;
    check("keys_ready_drop", 64'(bus.keys_ready), 64'd0);
    for (int c = 0; c < 28; c++) begin
      check("busy_exp", 64'(bus.busy), 64'd1);
      check("rnd_idx", 64'(bus.rnd_idx), 64'(c));
      check("key_ready_exp", 64'(bus.key_ready), 64'd0);
      check("keys_ready_exp", 64'(bus.keys_ready), 64'd0);
      check("rd_key_gated", 64'(bus.rd_key), 64'd0);
      @(posedge clk); #1;
    end
    bus.key_valid = 1'b0;
    check("keys_ready_rise", 64'(bus.keys_ready), 64'd1);
    check("busy_done", 64'(bus.busy), 64'd0);
    check("rnd_idx_done", 64'(bus.rnd_idx), 64'd0);
    check("key_ready_done", 64'(bus.key_ready), 64'd1);
    gen_model(key);
    for (int a = 0; a < 32; a++) begin
      bus.rd_addr = 5'(a);
      #1;
      check("rd_key_model", 64'(bus.rd_key), 64'(exp_k[a]));
    end
  endtask

  initial begin
    bus.key_valid   = 1'b0;
    bus.master_key  = '0;
    bus.rd_addr     = '0;
    bus8.key_valid  = 1'b0;
    bus8.master_key = '0;
    bus8.rd_addr    = '0;
`ifdef KEY_EXP_ZEROIZE_EN
    bus.zeroize     = 1'b0;
    bus8.zeroize    = 1'b0;
`endif

    // Reset values while rst_n is low
    #1 rst_n = 1'b0;
    #2;
    check("rst_key_ready", 64'(bus.key_ready), 64'd1);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_keys_ready", 64'(bus.keys_ready), 64'd0);
    check("rst_rd_key", 64'(bus.rd_key), 64'd0);
    check("rst_rnd_idx", 64'(bus.rnd_idx), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Reference vector with hand-computed words
    expand_and_check(KeyA, 1'b0, 64'd0);
    bus.rd_addr = 5'd0; #1 check("k0", 64'(bus.rd_key), 64'h0100);
    bus.rd_addr = 5'd1; #1 check("k1", 64'(bus.rd_key), 64'h0908);
    bus.rd_addr = 5'd2; #1 check("k2", 64'(bus.rd_key), 64'h1110);
    bus.rd_addr = 5'd3; #1 check("k3", 64'(bus.rd_key), 64'h1918);
    bus.rd_addr = 5'd4; #1 check("k4", 64'(bus.rd_key), 64'h71C3);
    @(posedge clk); #1;

    // key_valid held through EXPAND with another key: must be ignored
    expand_and_check(KeyA, 1'b1, KeyB);
    @(posedge clk); #1;

    // Reset at i = 10
    bus.master_key = KeyB;
    bus.key_valid  = 1'b1;
    @(posedge clk); #1 bus.key_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 check("idx_before_rst", 64'(bus.rnd_idx), 64'd10);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 64'(bus.busy), 64'd0);
    check("mid_rst_keys_ready", 64'(bus.keys_ready), 64'd0);
    check("mid_rst_rd_key", 64'(bus.rd_key), 64'd0);
    check("mid_rst_key_ready", 64'(bus.key_ready), 64'd1);
    check("mid_rst_rnd_idx", 64'(bus.rnd_idx), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_keys_ready", 64'(bus.keys_ready), 64'd0);
    expand_and_check(KeyC, 1'b0, 64'd0);

    // Rekey in DONE with an all-zero key
    check("done_before_rekey", 64'(bus.keys_ready), 64'd1);
    expand_and_check(64'd0, 1'b0, 64'd0);
    bus.rd_addr = 5'd0; #1 check("zero_key_k0", 64'(bus.rd_key), 64'h0000);
    @(posedge clk); #1;

    // Short schedule: ROUNDS = 8
    bus8.master_key = KeyA;
    bus8.key_valid  = 1'b1;
    @(posedge clk); #1 bus8.key_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("r8_busy", 64'(bus8.busy), 64'd1);
    check("r8_keys_ready_early", 64'(bus8.keys_ready), 64'd0);
    @(posedge clk); #1;
    check("r8_keys_ready", 64'(bus8.keys_ready), 64'd1);
    check("r8_busy_done", 64'(bus8.busy), 64'd0);
    gen_model(KeyA);
    bus8.rd_addr = 5'd4;  #1 check("r8_k4", 64'(bus8.rd_key), 64'h71C3);
    bus8.rd_addr = 5'd7;  #1 check("r8_k7", 64'(bus8.rd_key), 64'(exp_k[7]));
    bus8.rd_addr = 5'd8;  #1 check("r8_oob8", 64'(bus8.rd_key), 64'd0);
    bus8.rd_addr = 5'd31; #1 check("r8_oob31", 64'(bus8.rd_key), 64'd0);
    @(posedge clk); #1;

`ifdef KEY_EXP_ZEROIZE_EN
    // Zeroize in DONE
    expand_and_check(KeyA, 1'b0, 64'd0);
    bus.zeroize = 1'b1;
    @(posedge clk); #1 bus.zeroize = 1'b0;
    check("zz_keys_ready", 64'(bus.keys_ready), 64'd0);
    check("zz_busy", 64'(bus.busy), 64'd0);
    check("zz_key_ready", 64'(bus.key_ready), 64'd1);
    for (int n = 0; n < 32; n++) check("zz_store", 64'(u_dut.r_store[n]), 64'd0);

    // Zeroize together with key_valid: zeroize wins
    expand_and_check(KeyA, 1'b0, 64'd0);
    bus.zeroize    = 1'b1;
    bus.key_valid  = 1'b1;
    bus.master_key = KeyB;
    @(posedge clk); #1;
    bus.zeroize   = 1'b0;
    bus.key_valid = 1'b0;
    check("zzkv_busy", 64'(bus.busy), 64'd0);
    check("zzkv_keys_ready", 64'(bus.keys_ready), 64'd0);
    for (int n = 0; n < 32; n++) check("zzkv_store", 64'(u_dut.r_store[n]), 64'd0);
    @(posedge clk); #1;
    check("zzkv_still_idle", 64'(bus.busy), 64'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/key_expansion_ctrl.md
KEY_EXPANSION_CTRL -- requirements
Module: key_expansion_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; these are the clk and rst_n ports.
REQ-002 Parameter: ROUNDS, default 32, number of round keys generated and stored (legal 5..32).
REQ-003 Port: clk  input  1  clock; all state updates on the rising edge.
REQ-004 Port: rst_n  input  1  asynchronous active-low reset.
REQ-005 Port: key_valid  input  1  master key offered.
REQ-006 Port: key_ready  output  1  controller can accept a master key.
REQ-007 Port: master_key  input  64  master key {k3,k2,k1,k0}, with k0 = master_key[15:0].
REQ-008 Port: busy  output  1  expansion in progress.
REQ-009 Port: keys_ready  output  1  all ROUNDS round keys valid in the store.
REQ-010 Port: rd_addr  input  5  round-key index requested by the cipher datapath.
REQ-011 Port: rd_key  output  16  round key at rd_addr, combinational read.
REQ-012 Port: rnd_idx  output  5  current expansion counter i.

Function
REQ-013 States: IDLE, EXPAND, DONE; key_ready = 1 in IDLE and DONE, 0 in EXPAND.
REQ-014 Handshake: a key is accepted on any edge where key_valid && key_ready; key_valid while key_ready = 0 is ignored.
REQ-015 On acceptance: store[0..3] <= k0..k3, i <= 0, state <= EXPAND, keys_ready <= 0.
REQ-016 EXPAND: each cycle store[i+4] <= c ^ z0[i] ^ store[i] ^ t ^ ror1(t), with t = ror3(store[i+3]) ^ store[i+1].
REQ-016a c = 16'hFFFC; z0[i] enters at bit 0 only; i <= i+1.
REQ-017 EXPAND lasts exactly ROUNDS-4 cycles; after writing store[ROUNDS-1], state <= DONE and keys_ready <= 1.
REQ-018 Latency: for acceptance at edge T, keys_ready = 1 from edge T+ROUNDS-4 onward (T+28 for the default).
REQ-019 busy = 1 exactly in EXPAND; rnd_idx = i in EXPAND and 0 otherwise.
REQ-020 rd_key = store[rd_addr] when keys_ready = 1; otherwise 16'h0000.
REQ-020a rd_key = 16'h0000 when rd_addr >= ROUNDS.
REQ-021 Rekey: acceptance in DONE restarts at REQ-015; keys_ready falls at the same edge.
REQ-022 i is 5 bits and never wraps: the counter stops at ROUNDS-4.

Reset
REQ-023 rst_n low SHALL asynchronously force state = IDLE, i = 0, keys_ready = 0 and busy = 0.
REQ-023a While rst_n is low, key_ready = 1 and rd_key = 0.
REQ-024 Reset during EXPAND SHALL abandon the expansion; no partial keys_ready is ever asserted.
REQ-025 The store array SHALL not be reset; it is qualified by keys_ready.

Configuration
REQ-026 Macro KEY_EXP_ZEROIZE_EN SHALL control key zeroization.
REQ-026a Defined: adds input zeroize (1 bit). In any state, zeroize = 1 clears all store entries to 0, i to 0 and keys_ready to 0, and sets state = IDLE, at the next edge.
REQ-026a1 zeroize has priority over a simultaneous key acceptance.
REQ-026b Undefined: no zeroize port and no clearing logic; the store is only overwritten by expansion.

Structure
REQ-027 The shared package SHALL hold Z0 = 62'b01100111000011010100100010111110110011100001101010010001011111, with z0[i] = Z0[i] (LSB first).
REQ-027a The shared package SHALL also hold C_CONST = 16'hFFFC and the state enum type.
REQ-028 One combinational sub-module, key_round_fn, SHALL compute the next key from (store[i..i+3], z0[i]); the controller instantiates it once.

Verification
REQ-029 Bench: master_key = 64'h1918_1110_0908_0100, handshake at T. Required: rd_key at rd_addr 0..3 = 0100, 0908, 1110, 1918, and at rd_addr 4 = 16'h71C3 after keys_ready.
REQ-030 Bench: same key. Required: keys_ready rises exactly 28 cycles after acceptance; busy high for 28 cycles; rnd_idx steps 0..27; k4..k31 match the golden model.
REQ-031 Bench: key_valid held high in EXPAND with a different key. Required: ignored, key_ready = 0, results unchanged.
REQ-032 Bench: rst_n pulsed low at i = 10. Required: immediate IDLE, keys_ready = 0 and rd_key = 0; a fresh key then expands correctly.
REQ-033 Bench: rekey in DONE with 64'h0. Required: keys_ready drops at acceptance, rises 28 cycles later, and rd_key[0] = 0.
REQ-034 Bench (KEY_EXP_ZEROIZE_EN): zeroize in DONE, and separately zeroize with a simultaneous key_valid. Required: store all zero, IDLE, no key accepted.
